// File: rtl/contador_param.sv
// Parameterised up/down modulo counter with enable-gated prescaler,
// synchronous clamped load and registered tick/terminal-count pulses.
//
// Ports:
//   clk   - system clock, all state on the rising edge
//   rst   - synchronous active-high reset
//   en    - count enable, gates prescaler and counter
//   up    - direction, 1 = increment, 0 = decrement
//   load  - synchronous load strobe (wins over a coincident step)
//   dado  - load value, clamped to MODULO-1
//   saida - registered count value, always in 0..MODULO-1
//   tick  - one-cycle pulse alongside each new stepped value
//   tc    - one-cycle pulse alongside tick when the step wrapped
module contador_param #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 10,
  parameter int DIV    = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] dado,
  output logic [WIDTH-1:0] saida,
  output logic             tick,
  output logic             tc
);

  // Minimum bits to hold DIV-1, never less than one.
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0]    PRE_MAX = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULO - 1);

  logic [PW-1:0]    r_pre;
  logic [WIDTH-1:0] r_cnt;
  logic             r_tick;
  logic             r_tc;

  logic             w_step;
  logic             w_wrap;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load;

  assign w_step = en && (r_pre == PRE_MAX);

  // Wrap condition depends on direction only, not on step.
  assign w_wrap = up ? (r_cnt == CNT_MAX)
                     : (r_cnt == '0);

  always_comb begin
    w_next = r_cnt;
    if (up) begin
      w_next = w_wrap ? '0 : r_cnt + 1'b1;
    end else begin
      w_next = w_wrap ? CNT_MAX : r_cnt - 1'b1;
    end
  end

  // Compare in 32 bits so MODULO = 2^WIDTH never clamps.
  always_comb begin
    w_load = dado;
    if (32'(dado) >= 32'(MODULO)) begin
      w_load = CNT_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre  <= '0;
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_tc   <= 1'b0;
    end else if (load) begin
      r_pre  <= '0;
      r_cnt  <= w_load;
      r_tick <= 1'b0;
      r_tc   <= 1'b0;
    end else begin
      r_tick <= w_step;
      r_tc   <= w_step && w_wrap;
      if (en) begin
        r_pre <= w_step ? '0 : r_pre + 1'b1;
      end
      if (w_step) begin
        r_cnt <= w_next;
      end
    end
  end

  assign saida = r_cnt;
  assign tick  = r_tick;
  assign tc    = r_tc;

endmodule

// File: tb/tb_contador_param.sv
// Directed bench for contador_param: vector table plus hand sequences.
// Instance a: WIDTH=4 MODULO=10 DIV=4; instance b: WIDTH=4 MODULO=16 DIV=1.
module tb_contador_param;

  typedef struct {
    logic       rst;
    logic       en;
    logic       up;
    logic       ld;
    logic [3:0] dado;
    logic [3:0] s;
    logic       t;
    logic       c;
    string      nm;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, up = 1'b1, load = 1'b0;
  logic [3:0] dado = '0;
  logic [3:0] saida;
  logic       tick, tc;

  logic       en1 = 1'b0, up1 = 1'b1, load1 = 1'b0;
  logic [3:0] dado1 = '0;
  logic [3:0] saida1;
  logic       tick1, tc1;

  int n_chk = 0;
  int n_pass = 0;

  vec_t tbl[$];

  always #5 clk = ~clk;

  contador_param #(.WIDTH(4), .MODULO(10), .DIV(4)) u_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .dado(dado), .saida(saida), .tick(tick), .tc(tc)
  );

  contador_param #(.WIDTH(4), .MODULO(16), .DIV(1)) u_b (
    .clk(clk), .rst(rst), .en(en1), .up(up1), .load(load1),
    .dado(dado1), .saida(saida1), .tick(tick1), .tc(tc1)
  );

  task automatic add(input string nm, input bit r, e, u, l,
                     input int d, s, t, c);
    vec_t v;
    v.nm = nm;
    v.rst = r; v.en = e; v.up = u; v.ld = l;
    v.dado = 4'(d); v.s = 4'(s); v.t = t[0]; v.c = c[0];
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm,
                     input logic [3:0] as, input logic at, input logic ac,
                     input logic [3:0] es, input logic et, input logic ec);
    n_chk++;
    if (as === es && at === et && ac === ec) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got saida=%0d tick=%b tc=%b, want saida=%0d tick=%b tc=%b",
               nm, as, at, ac, es, et, ec);
    end
  endtask

  task automatic drive(input bit r, e, u, l, input int d);
    rst = r; en = e; up = u; load = l; dado = 4'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input string nm, input bit r, e, u, l,
                       input int d, s, t, c);
    drive(r, e, u, l, d);
    chk(nm, saida, tick, tc, 4'(s), t[0], c[0]);
  endtask

  initial begin
    // name, rst, en, up, load, dado, saida, tick, tc
    add("rst_over_load", 1, 0, 1, 1, 5, 0, 0, 0);
    add("post_rst_c1",   0, 1, 1, 0, 0, 0, 0, 0);
    add("post_rst_c2",   0, 1, 1, 0, 0, 0, 0, 0);
    add("post_rst_c3",   0, 1, 1, 0, 0, 0, 0, 0);
    add("first_tick",    0, 1, 1, 0, 0, 1, 1, 0);
    add("load_clamp12",  0, 1, 1, 1, 12, 9, 0, 0);
    add("after_ld_c1",   0, 1, 1, 0, 0, 9, 0, 0);
    add("after_ld_c2",   0, 1, 1, 0, 0, 9, 0, 0);
    add("after_ld_c3",   0, 1, 1, 0, 0, 9, 0, 0);
    add("wrap_9_to_0",   0, 1, 1, 0, 0, 0, 1, 1);
    add("en_off_hold",   0, 0, 1, 0, 0, 0, 0, 0);
    add("pre_c1",        0, 1, 1, 0, 0, 0, 0, 0);
    add("pre_c2",        0, 1, 1, 0, 0, 0, 0, 0);
    add("pre_c3",        0, 1, 1, 0, 0, 0, 0, 0);
    add("load_in_step",  0, 1, 1, 1, 5, 5, 0, 0);
    add("ld_step_c1",    0, 1, 1, 0, 0, 5, 0, 0);
    add("ld_step_c2",    0, 1, 1, 0, 0, 5, 0, 0);
    add("ld_step_c3",    0, 1, 1, 0, 0, 5, 0, 0);
    add("ld_step_tick",  0, 1, 1, 0, 0, 6, 1, 0);
    add("dir_chg_c1",    0, 1, 0, 0, 0, 6, 0, 0);
    add("dir_chg_c2",    0, 1, 0, 0, 0, 6, 0, 0);
    add("dir_chg_c3",    0, 1, 0, 0, 0, 6, 0, 0);
    add("dir_chg_step",  0, 1, 0, 0, 0, 5, 1, 0);
    add("load_max_9",    0, 0, 1, 1, 9, 9, 0, 0);
    add("mid_pre_c1",    0, 1, 1, 0, 0, 9, 0, 0);
    add("rst_mid_pre",   1, 1, 1, 0, 0, 0, 0, 0);
    add("rr_c1",         0, 1, 1, 0, 0, 0, 0, 0);
    add("rr_c2",         0, 1, 1, 0, 0, 0, 0, 0);
    add("rr_c3",         0, 1, 1, 0, 0, 0, 0, 0);
    add("rr_tick",       0, 1, 1, 0, 0, 1, 1, 0);

    foreach (tbl[i]) begin
      run_a(tbl[i].nm, tbl[i].rst, tbl[i].en, tbl[i].up, tbl[i].ld,
            int'(tbl[i].dado), int'(tbl[i].s), int'(tbl[i].t), int'(tbl[i].c));
    end

    // Up count across a full wrap from reset.
    run_a("upw_rst", 1, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 40; k++) begin
      int es;
      bit et;
      es = (k / 4) % 10;
      et = (k % 4) == 0;
      run_a($sformatf("upw_k%0d", k), 0, 1, 1, 0, 0,
            es, int'(et), int'(et && es == 0));
    end

    // Down wrap from zero.
    run_a("dn_load0", 0, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      int es;
      bit et;
      es = (k < 4) ? 0 : (k < 8) ? 9 : 8;
      et = (k % 4) == 0;
      run_a($sformatf("dn_k%0d", k), 0, 1, 0, 0, 0,
            es, int'(et), int'(k == 4));
    end

    // Enable gating with pre parked at 2.
    run_a("eg_load3", 0, 0, 1, 1, 3, 3, 0, 0);
    run_a("eg_c1", 0, 1, 1, 0, 0, 3, 0, 0);
    run_a("eg_c2", 0, 1, 1, 0, 0, 3, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      run_a($sformatf("eg_off%0d", k), 0, 0, 1, 0, 0, 3, 0, 0);
    end
    run_a("eg_re1", 0, 1, 1, 0, 0, 3, 0, 0);
    run_a("eg_tick", 0, 1, 1, 0, 0, 4, 1, 0);

    // DIV=1, MODULO=16: step every enabled cycle.
    rst = 1'b1; en = 1'b0;
    @(posedge clk);
    #1;
    chk("d1_rst", saida1, tick1, tc1, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    en1 = 1'b1; up1 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("d1_k%0d", k), saida1, tick1, tc1,
          4'(k % 16), 1'b1, 1'(k % 16 == 0));
    end
    en1 = 1'b0;
    @(posedge clk);
    #1;
    chk("d1_hold", saida1, tick1, tc1, 4'd4, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
